// File: rtl/fetch_stage.sv
// fetch_stage: PC select, instruction split/align, predicted-PC register and D pipeline register.
//   clk, rst_n                 clock, async active-low reset
//   imem_addr / imem_bytes     fetch address out, 10 instruction bytes in
//   imem_error                 fetch address out of range
//   f_stall, d_stall, d_bubble pipeline control
//   m_icode, m_cnd, m_valA     mispredicted-jump redirect
//   w_icode, w_valM            return redirect
//   d_*                        D register fields; f_pred_pc predicted-PC register
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] imem_addr,
    input  logic [79:0] imem_bytes,
    input  logic        imem_error,
    input  logic        f_stall,
    input  logic        d_stall,
    input  logic        d_bubble,
    input  logic [3:0]  m_icode,
    input  logic        m_cnd,
    input  logic [63:0] m_valA,
    input  logic [3:0]  w_icode,
    input  logic [63:0] w_valM,
    output logic [2:0]  d_stat,
    output logic [3:0]  d_icode,
    output logic [3:0]  d_ifun,
    output logic [3:0]  d_rA,
    output logic [3:0]  d_rB,
    output logic [63:0] d_valC,
    output logic [63:0] d_valP,
    output logic [63:0] f_pred_pc
);
    localparam logic [2:0] AOK = 3'd1, ADR = 3'd2, INS = 3'd3, HLT = 3'd4;
    logic        halted, mispredict, ret_redirect, redirect, halt_now, f_load, d_take;
    logic        bad, need_regids, need_valc;
    logic [3:0]  raw_icode, f_icode, f_ifun, f_ra, f_rb;
    logic [2:0]  f_stat;
    logic [63:0] f_valc, f_valp, next_pc;

    assign mispredict   = m_icode == 4'h7 && !m_cnd;
    assign ret_redirect = w_icode == 4'h9;
    assign redirect     = mispredict || ret_redirect;
    assign imem_addr    = mispredict ? m_valA : ret_redirect ? w_valM : f_pred_pc;

    assign raw_icode   = imem_bytes[7:4];
    assign bad         = imem_error || raw_icode > 4'hB;
    assign need_regids = raw_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    assign need_valc   = raw_icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    assign f_stat      = imem_error ? ADR : raw_icode > 4'hB ? INS : raw_icode == 4'h0 ? HLT : AOK;
    assign f_icode     = bad ? 4'h1 : raw_icode;
    assign f_ifun      = bad ? 4'h0 : imem_bytes[3:0];
    assign f_ra        = (bad || !need_regids) ? 4'hF : imem_bytes[15:12];
    assign f_rb        = (bad || !need_regids) ? 4'hF : imem_bytes[11:8];
    assign f_valc      = (bad || !need_valc) ? 64'd0 : need_regids ? imem_bytes[79:16] : imem_bytes[71:8];
    assign f_valp      = imem_addr + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);
    assign next_pc     = (f_icode == 4'h7 || f_icode == 4'h8) ? f_valc : f_valp;

    // A redirect overrides the halted freeze in the same cycle it arrives,
    // and also overrides f_stall so the redirect target's successor is captured.
    assign halt_now = halted && !redirect;
    assign f_load   = redirect || (!f_stall && !halt_now);
    assign d_take   = !d_stall && !d_bubble && !halt_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_pred_pc <= RESET_PC;
        end else if (f_load) begin
            f_pred_pc <= next_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (d_take && f_stat != AOK) begin
            halted <= 1'b1;
        end else if (redirect) begin
            halted <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP} <= {AOK, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0};
        end else if (d_stall) begin
            {d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP} <= {d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP};
        end else if (d_take) begin
            {d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP} <= {f_stat, f_icode, f_ifun, f_ra, f_rb, f_valc, f_valp};
        end else begin
            {d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP} <= {AOK, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0};
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven scoreboard bench for fetch_stage plus hand-written corner sequences.
module tb_fetch_stage;
    logic        clk = 0, rst_n = 0;
    logic [63:0] imem_addr, m_valA = 0, w_valM = 0, d_valC, d_valP, f_pred_pc;
    logic [79:0] imem_bytes = 0;
    logic        imem_error = 0, f_stall = 0, d_stall = 0, d_bubble = 0, m_cnd = 0;
    logic [3:0]  m_icode = 0, w_icode = 0, d_icode, d_ifun, d_rA, d_rB;
    logic [2:0]  d_stat;
    int errors = 0, checks = 0;

    typedef struct {
        logic [63:0] pc;
        logic [79:0] bytes;
        logic        err;
        logic [2:0]  stat;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp, pred;
        logic        chk_p;
    } vec_t;
    vec_t vecs[12];
    vec_t sb[$];
    vec_t e;

    fetch_stage #(.RESET_PC(64'h20)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_bytes(imem_bytes),
        .imem_error(imem_error), .f_stall(f_stall), .d_stall(d_stall), .d_bubble(d_bubble),
        .m_icode(m_icode), .m_cnd(m_cnd), .m_valA(m_valA), .w_icode(w_icode), .w_valM(w_valM),
        .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_rA(d_rA), .d_rB(d_rB),
        .d_valC(d_valC), .d_valP(d_valP), .f_pred_pc(f_pred_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_d(input string tag, input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp);
        chk({tag, ".stat"}, 64'(d_stat), 64'(st));
        chk({tag, ".icode"}, 64'(d_icode), 64'(ic));
        chk({tag, ".ifun"}, 64'(d_ifun), 64'(fn));
        chk({tag, ".rA"}, 64'(d_rA), 64'(ra));
        chk({tag, ".rB"}, 64'(d_rB), 64'(rb));
        chk({tag, ".valC"}, d_valC, vc);
        chk({tag, ".valP"}, d_valP, vp);
    endtask

    task automatic redirect_w(input logic [63:0] pc, input logic [79:0] b);
        w_icode = 4'h9; w_valM = pc; imem_bytes = b;
    endtask

    task automatic idle();
        w_icode = 0; m_icode = 0; m_cnd = 0; f_stall = 0; d_stall = 0; d_bubble = 0; imem_error = 0;
    endtask

    initial begin
        vecs[0]  = '{64'h0,  80'h0000_0000_0000_0010_F030, 0, 3'd1, 4'h3, 4'h0, 4'hF, 4'h0, 64'h10, 64'd10, 64'd10, 1};
        vecs[1]  = '{64'h20, 80'h0000_0000_0000_0000_4070, 0, 3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h29, 64'h40, 1};
        vecs[2]  = '{64'h100, 80'h0000_0000_0000_0000_0160, 0, 3'd1, 4'h6, 4'h0, 4'h0, 4'h1, 64'h0, 64'h102, 64'h102, 1};
        vecs[3]  = '{64'h30, 80'h0000_0000_0000_0002_0080, 0, 3'd1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h200, 64'h39, 64'h200, 1};
        vecs[4]  = '{64'h50, 80'h0000_0000_0000_0000_0090, 0, 3'd1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h51, 64'h51, 1};
        vecs[5]  = '{64'h10, 80'h1122_3344_5566_7788_2150, 0, 3'd1, 4'h5, 4'h0, 4'h2, 4'h1, 64'h1122334455667788, 64'h1A, 64'h1A, 1};
        vecs[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 80'h10, 0, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 1};
        vecs[7]  = '{64'h60, 80'h0000_0000_0000_0000_12F0, 0, 3'd3, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 0};
        vecs[8]  = '{64'h8,  80'h00, 0, 3'd4, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h9, 64'h9, 1};
        vecs[9]  = '{64'h70, 80'h0000_0000_0000_0010_F030, 1, 3'd2, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 0};
        vecs[10] = '{64'h70, 80'h3421, 0, 3'd1, 4'h2, 4'h1, 4'h3, 4'h4, 64'h0, 64'h72, 64'h72, 1};
        vecs[11] = '{64'h80, 80'h0FA0, 0, 3'd1, 4'hA, 4'h0, 4'h0, 4'hF, 64'h0, 64'h82, 64'h82, 1};

        #12;
        chk("reset.pred", f_pred_pc, 64'h20);
        chk("reset.addr", imem_addr, 64'h20);
        chk_d("reset", 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        rst_n = 1;
        tick();

        for (int i = 0; i < 12; i++) begin
            redirect_w(vecs[i].pc, vecs[i].bytes);
            imem_error = vecs[i].err;
            sb.push_back(vecs[i]);
            tick();
            e = sb.pop_front();
            chk_d($sformatf("vec%0d", i), e.stat, e.icode, e.ifun, e.ra, e.rb, e.valc, e.chk_p ? e.valp : d_valP);
            if (e.chk_p) chk($sformatf("vec%0d.pred", i), f_pred_pc, e.pred);
        end
        idle();

        redirect_w(64'h20, 80'h4070);
        m_icode = 4'h7; m_cnd = 0; m_valA = 64'h29; #1;
        chk("mispredict.prio", imem_addr, 64'h29);
        m_cnd = 1; #1;
        chk("taken.ret", imem_addr, 64'h20);
        idle(); #1;
        chk("idle.addr", imem_addr, f_pred_pc);

        redirect_w(64'h60, 80'hF0);
        tick();
        chk_d("ins", 3'd3, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, d_valP);
        redirect_w(64'h8, 80'h00);
        tick();
        chk_d("hlt", 3'd4, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h9);
        idle(); imem_bytes = 80'h10;
        tick(); tick();
        chk_d("halted", 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        chk("halted.pred", f_pred_pc, 64'h9);
        w_icode = 4'h9; w_valM = 64'h100; #1;
        chk("resume.addr", imem_addr, 64'h100);
        tick(); idle();
        chk_d("resume", 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h101);
        chk("resume.pred", f_pred_pc, 64'h101);

        imem_bytes = 80'h0160; f_stall = 1; d_stall = 1;
        repeat (3) tick();
        chk("stall.pred", f_pred_pc, 64'h101);
        chk_d("stall", 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h101);
        idle(); tick();
        chk_d("unstall", 3'd1, 4'h6, 4'h0, 4'h0, 4'h1, 64'h0, 64'h103);
        chk("unstall.pred", f_pred_pc, 64'h103);

        d_stall = 1; d_bubble = 1; imem_bytes = 80'h10;
        tick();
        chk("stall_bubble.icode", 64'(d_icode), 64'h6);
        d_stall = 0; tick(); idle();
        chk_d("bubble", 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        chk("bubble.pred", f_pred_pc, 64'h105);

        f_stall = 1; redirect_w(64'h200, 80'h10);
        tick(); idle();
        chk("fstall_redirect.pred", f_pred_pc, 64'h201);

        imem_bytes = 80'h0160; tick();
        @(negedge clk); rst_n = 0; #1;
        chk("areset.pred", f_pred_pc, 64'h20);
        chk_d("areset", 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        #3 rst_n = 1; #1;
        chk("release.addr", imem_addr, 64'h20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
